// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_cap_pkg;

  typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

  localparam int DUTY_W    = 7;
  localparam int DIV_LAT   = 8;
  localparam int PCT_SCALE = 100;

endpackage

// File: rtl/pwm_cap_div.sv
// Sequential restoring divider producing floor(num*100/den) as a 7-bit quotient.
// One load cycle, seven iterations, then one hand-off cycle before accepting a new start.
module pwm_cap_div
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quo
);

  localparam int W = CNT_W + DUTY_W;
  localparam logic [2:0] IDX_LAST = 3'(DUTY_W - 1);
  localparam logic [2:0] IDX_HAND = 3'(DIV_LAT - 1);

  logic              busy_q;
  logic [2:0]        idx_q;
  logic [W-1:0]      rem_q;
  logic [W-1:0]      dsh_q;
  logic [DUTY_W-1:0] quo_q;
  logic              take;
  logic [DUTY_W-1:0] quo_nxt;

  always_comb begin
    take    = (rem_q >= dsh_q);
    quo_nxt = {quo_q[DUTY_W-2:0], take};
  end

  assign busy = busy_q;
  // done fires during the last iteration so the caller can register quo_nxt on that edge
  assign done = busy_q && (idx_q == IDX_LAST);
  assign quo  = quo_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        idx_q  <= '0;
        rem_q  <= W'(num) * W'(PCT_SCALE);
        dsh_q  <= W'(den) << (DUTY_W - 1);
        quo_q  <= '0;
      end
    end else begin
      idx_q <= idx_q + 3'd1;
      if (idx_q == IDX_HAND) begin
        busy_q <= 1'b0;
      end else begin
        if (take) begin
          rem_q <= rem_q - dsh_q;
        end
        dsh_q <= dsh_q >> 1;
        quo_q <= quo_nxt;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time, period and duty percentage of an external PWM waveform, rising edge to rising edge.
// Optional glitch filter between synchronizer and edge detector: define GLITCH_FILTER_EN.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  input  logic              clr_ovr,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  period,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              meas_valid,
  output logic              stuck,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   lvl;
  logic                   lvl_q;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  logic [FILT_LEN-2:0] filt_hist;
  logic                filt_lvl;

  // Level follows the input only once FILT_LEN consecutive samples agree
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt_hist <= '0;
      filt_lvl  <= 1'b0;
    end else begin
      filt_hist <= (FILT_LEN-1)'({filt_hist, sync_lvl});
      if (&{filt_hist, sync_lvl}) begin
        filt_lvl <= 1'b1;
      end else if (~|{filt_hist, sync_lvl}) begin
        filt_lvl <= 1'b0;
      end
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sync_lvl;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= CNT_W'(1);
    end else if (!cnt_sat) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_sat = (cnt_q == CNT_MAX);

  state_t state_q;
  state_t state_nxt;
  logic   div_start;
  logic   div_busy;
  logic   div_done;
  logic [DUTY_W-1:0] div_quo;
  logic   drop;
  logic   cap_h;
  logic   tmo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SEEK;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      SEEK: if (rise) state_nxt = HIGH;
      HIGH: begin
        if (fall)         state_nxt = LOW;
        else if (cnt_sat) state_nxt = SEEK;
      end
      LOW: begin
        if (rise)         state_nxt = HIGH;
        else if (cnt_sat) state_nxt = SEEK;
      end
      default: state_nxt = SEEK;
    endcase
  end

  always_comb begin
    div_start = 1'b0;
    drop      = 1'b0;
    cap_h     = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      HIGH: begin
        if (fall)         cap_h = 1'b1;
        else if (cnt_sat) tmo   = 1'b1;
      end
      LOW: begin
        if (rise) begin
          div_start = !div_busy;
          drop      = div_busy;
        end else if (cnt_sat) begin
          tmo = 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic [CNT_W-1:0] h_shadow;
  logic [CNT_W-1:0] h_hold;
  logic [CNT_W-1:0] p_shadow;

  pwm_cap_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .num  (h_shadow),
    .den  (cnt_q),
    .busy (div_busy),
    .done (div_done),
    .quo  (div_quo)
  );

  // h_hold/p_shadow freeze the operands so a falling edge during division cannot skew high_time
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_shadow   <= '0;
      h_hold     <= '0;
      p_shadow   <= '0;
      high_time  <= '0;
      period     <= '0;
      duty_pct   <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (cap_h) begin
        h_shadow <= cnt_q;
      end
      if (div_start) begin
        h_hold   <= h_shadow;
        p_shadow <= cnt_q;
      end
      if (div_done) begin
        high_time  <= h_hold;
        period     <= p_shadow;
        duty_pct   <= div_quo;
        meas_valid <= 1'b1;
        stuck      <= 1'b0;
      end else if (tmo) begin
        duty_pct   <= (state_q == HIGH) ? DUTY_W'(PCT_SCALE) : '0;
        meas_valid <= 1'b1;
        stuck      <= 1'b1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected measurements queued at each closing rising edge, checked on meas_valid.
module tb_pwm_capture;

  localparam int CNT_W = 16;
`ifdef GLITCH_FILTER_EN
  localparam int OVR_H = 3;
  localparam int OVR_P = 6;
`else
  localparam int OVR_H = 2;
  localparam int OVR_P = 5;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b0;
  logic             clr_ovr = 1'b0;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             stuck;
  logic             overrun;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .FILT_LEN   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .clr_ovr   (clr_ovr),
    .high_time (high_time),
    .period    (period),
    .duty_pct  (duty_pct),
    .meas_valid(meas_valid),
    .stuck     (stuck),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int p;
    int d;
    int s;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m_open = 0;
  int   m_h = 0;
  int   m_p = 0;
  int   m_rep_h = 0;
  int   m_rep_p = 0;
  int   m_last_acc = -1000;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_meas_valid", 32'(meas_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("high_time", 32'(high_time), e.h);
        chk("period",    32'(period),    e.p);
        chk("duty_pct",  32'(duty_pct),  e.d);
        chk("stuck",     32'(stuck),     e.s);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_meas(input int h, input int p);
    sb.push_back('{h: h, p: p, d: (h * 100) / p, s: 0});
    m_rep_h = h;
    m_rep_p = p;
  endtask

  // A rising edge closes the open period; it is measured only if the previous accepted one is >= 9 cycles back
  task automatic on_rise();
    if (m_open != 0) begin
      if (cyc - m_last_acc >= 9) begin
        push_meas(m_h, m_p);
        m_last_acc = cyc;
      end
    end
  endtask

  task automatic period_drive(input int h, input int p);
    on_rise();
    m_open = 1;
    m_h = h;
    m_p = p;
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic period_glitch();
    on_rise();
    m_open = 1;
    m_h = 50;
    m_p = 200;
    pwm_in = 1'b1;
    tick(50);
    pwm_in = 1'b0;
    tick(40);
    pwm_in = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(108);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high_time"},  32'(high_time),  32'd0);
    chk({tag, "_period"},     32'(period),     32'd0);
    chk({tag, "_duty_pct"},   32'(duty_pct),   32'd0);
    chk({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    chk({tag, "_stuck"},      32'(stuck),      32'd0);
    chk({tag, "_overrun"},    32'(overrun),    32'd0);
  endtask

  initial begin
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    tick(5);

    repeat (4) period_drive(64, 256);
    repeat (3) period_drive(333, 1000);
    repeat (2) period_drive(999, 1000);
    chk("overrun_idle", 32'(overrun), 32'd0);

    on_rise();
    m_open = 0;
    sb.push_back('{h: m_rep_h, p: m_rep_p, d: 100, s: 1});
    pwm_in = 1'b1;
    tick(65600);
    @(negedge clk);
    chk("stuck_set", 32'(stuck), 32'd1);
    tick(1);
    pwm_in = 1'b0;
    tick(20);
    repeat (3) period_drive(50, 100);
    chk("stuck_cleared", 32'(stuck), 32'd0);

    repeat (7) period_drive(OVR_H, OVR_P);
    tick(20);
    @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    tick(1);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", 32'(overrun), 32'd0);
    tick(1);

    // Closing edge starts the divider, then reset lands mid-division and must discard it
    pwm_in = 1'b1;
    tick(3);
    pwm_in = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    chk_all_zero("rst_busy");
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("post_rst_period", 32'(period), 32'd0);
    m_open = 0;
    tick(20);
    repeat (2) period_drive(64, 256);

`ifdef GLITCH_FILTER_EN
    repeat (3) period_glitch();
`endif

    on_rise();
    m_open = 0;
    pwm_in = 1'b1;
    tick(5);
    pwm_in = 1'b0;
    tick(30);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
